// File: rtl/seq_div_16bit_pkg.sv
// ---------------------------------------------------------------------------
// seq_div_16bit_pkg
// Shared definitions for the iterative arithmetic blocks: datapath widths,
// FSM state encodings and the quotient reported for a zero divisor.
// Other arithmetic FSM blocks import this package too, so the state
// encodings are pinned to fixed values.
// ---------------------------------------------------------------------------
package seq_div_16bit_pkg;

  // Operand/result width; tied to the 16-bit carry-lookahead adder.
  localparam int WIDTH = 16;
  // Iteration counter width; must be able to hold WIDTH.
  localparam int CNT_W = 5;

  // Quotient value returned when the divisor is zero.
  localparam logic [WIDTH-1:0] DIV_ZERO_Q = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_16bit.sv
// ---------------------------------------------------------------------------
// cla_16bit
// 16-bit carry-lookahead adder built from four 4-bit groups. Each group
// produces generate/propagate terms so the group carries are resolved by
// lookahead instead of rippling through all 16 bits.
// Ports:
//   a, b  : 16-bit addends
//   cin   : carry in
//   sum   : 16-bit sum
//   cout  : carry out of bit 15
// ---------------------------------------------------------------------------
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [16:0] w_c;
  logic [3:0]  w_grpP;
  logic [3:0]  w_grpG;
  logic [4:0]  w_grpC;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Group-level lookahead: each 4-bit group reports whether it generates a
  // carry or propagates its incoming one, and the carry into each group is
  // derived from those terms. Bit carries inside a group then follow from
  // the group's own carry-in.
  always_comb begin
    w_grpP = '0;
    w_grpG = '0;
    w_grpC = '0;
    w_c    = '0;
    w_grpC[0] = cin;
    for (int k = 0; k < 4; k++) begin
      w_grpP[k] = &w_p[4*k +: 4];
      w_grpG[k] = w_g[4*k+3]
                | (w_p[4*k+3] & w_g[4*k+2])
                | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_grpC[k+1] = w_grpG[k] | (w_grpP[k] & w_grpC[k]);
    end
    for (int k = 0; k < 4; k++) begin
      w_c[4*k] = w_grpC[k];
      for (int j = 0; j < 3; j++) begin
        w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
      end
    end
    w_c[16] = w_grpC[4];
  end

  assign sum  = w_p ^ w_c[15:0];
  assign cout = w_c[16];

endmodule

// File: rtl/seq_div_16bit.sv
// ---------------------------------------------------------------------------
// seq_div_16bit
// Iterative 16-bit unsigned restoring divider, one quotient bit per clock,
// MSB first. The trial subtraction reuses cla_16bit as rem + ~divisor + 1.
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   start        : request, sampled only in IDLE or DONE
//   a, b         : dividend / divisor, captured on the accepted start edge
//   q, r         : quotient / remainder, updated only on entry to DONE
//   busy         : high while iterating
//   done         : one-clock pulse when q/r are valid
//   div_by_zero  : set with done when the captured divisor was zero
// ---------------------------------------------------------------------------
module seq_div_16bit
  import seq_div_16bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t           r_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_cout;
  logic             w_success;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quotNext;

  // Shift the next dividend bit into the partial remainder. The result is
  // 17 bits wide because the shifted remainder can exceed 16 bits.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};

  // Trial subtraction of the divisor from the low 16 bits of the shift.
  cla_16bit u_sub (
    .a    (w_shift[WIDTH-1:0]),
    .b    (~r_divisor),
    .cin  (1'b1),
    .sum  (w_diff),
    .cout (w_cout)
  );

  // The subtraction succeeds if the shift overflowed 16 bits (then it is
  // certainly >= divisor, and the low-16 difference is still exact) or
  // the adder reported no borrow.
  assign w_success  = w_shift[WIDTH] | w_cout;
  assign w_remNext  = w_success ? w_diff : w_shift[WIDTH-1:0];
  assign w_quotNext = {r_quot[WIDTH-2:0], w_success};

  // Control FSM and datapath registers. A start in IDLE or DONE captures
  // the operands; a zero divisor skips the iterations entirely. In CALC
  // the start input and operands are ignored. q and r are only written on
  // entry to DONE so partial results never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_dvd       <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_cnt       <= '0;
      q           <= '0;
      r           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_dvd     <= a;
            r_divisor <= b;
            r_rem     <= '0;
            r_quot    <= '0;
            r_cnt     <= CNT_W'(WIDTH);
            if (b == '0) begin
              q           <= DIV_ZERO_Q;
              r           <= a;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              r_state     <= ST_CALC;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_rem  <= w_remNext;
          r_quot <= w_quotNext;
          r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            q       <= w_quotNext;
            r       <= w_remNext;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_16bit.sv
// ---------------------------------------------------------------------------
// tb_seq_div_16bit
// Self-checking bench for seq_div_16bit. Expected results come from plain
// integer division (a / b, a % b) with the zero-divisor rule applied on
// top; handshake timing is checked cycle by cycle relative to the capture
// edge.
// ---------------------------------------------------------------------------
module tb_seq_div_16bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] q;
  logic [15:0] r;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  seq_div_16bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .q           (q),
    .r           (r),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present operands and raise start ahead of the next rising edge.
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb2);
    @(negedge clk);
    a     = ta;
    b     = tb2;
    start = 1'b1;
  endtask

  // Full operation: capture, then check busy over the 16 iteration clocks,
  // the done pulse in the 17th clock and the results against plain
  // arithmetic. If repulseAt is non-zero, a bogus start with 9/2 is pulsed
  // during that iteration clock and must be ignored.
  task automatic runDivide(input logic [15:0] ta, input logic [15:0] tb2,
                           input int repulseAt);
    logic [15:0] expQ;
    logic [15:0] expR;
    int          badTiming;
    expQ = (tb2 == 16'd0) ? 16'hFFFF : ta / tb2;
    expR = (tb2 == 16'd0) ? ta : ta % tb2;
    applyStimulus(ta, tb2);
    @(posedge clk);
    #1 start = 1'b0;
    if (tb2 == 16'd0) begin
      checkOutput("dz_done", {31'd0, done}, 32'd1);
      checkOutput("dz_busy", {31'd0, busy}, 32'd0);
      checkOutput("dz_flag", {31'd0, div_by_zero}, 32'd1);
      checkOutput("dz_q", {16'd0, q}, {16'd0, expQ});
      checkOutput("dz_r", {16'd0, r}, {16'd0, expR});
    end else begin
      badTiming = 0;
      for (int i = 1; i <= 16; i++) begin
        if (busy !== 1'b1 || done !== 1'b0) badTiming++;
        if (i == repulseAt) begin
          a     = 16'd9;
          b     = 16'd2;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        #1;
      end
      start = 1'b0;
      checkOutput("busy_window", badTiming, 32'd0);
      checkOutput("done_at_17", {31'd0, done}, 32'd1);
      checkOutput("busy_off", {31'd0, busy}, 32'd0);
      checkOutput("q", {16'd0, q}, {16'd0, expQ});
      checkOutput("r", {16'd0, r}, {16'd0, expR});
      checkOutput("dz_clear", {31'd0, div_by_zero}, 32'd0);
    end
    @(posedge clk);
    #1;
    checkOutput("done_pulse_end", {31'd0, done}, 32'd0);
    checkOutput("q_hold", {16'd0, q}, {16'd0, expQ});
  endtask

  initial begin
    int          badBusy;
    int          doneSeen;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] recon;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_q", {16'd0, q}, 32'd0);
    checkOutput("rst_r", {16'd0, r}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed operations.
    $display("[TB] directed operations");
    runDivide(16'd100, 16'd7, 0);
    runDivide(16'hC61F, 16'h018C, 0);
    runDivide(16'hFFFF, 16'h0001, 0);
    runDivide(16'hFFFF, 16'hFFFF, 0);
    runDivide(16'd3, 16'd10, 0);
    runDivide(16'd5, 16'd0, 0);

    // Start re-pulsed mid-calculation must be ignored.
    $display("[TB] start ignored while busy");
    runDivide(16'd100, 16'd7, 5);

    // Back-to-back: start stays high through DONE, second operands
    // presented while the first operation is still running.
    $display("[TB] back-to-back capture");
    applyStimulus(16'd200, 16'd9);
    @(posedge clk);
    #1;
    a = 16'd1000;
    b = 16'd33;
    repeat (16) @(posedge clk);
    #1;
    checkOutput("b2b_done1", {31'd0, done}, 32'd1);
    checkOutput("b2b_q1", {16'd0, q}, 32'd22);
    checkOutput("b2b_r1", {16'd0, r}, 32'd2);
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("b2b_busy2", {31'd0, busy}, 32'd1);
    checkOutput("b2b_done2_low", {31'd0, done}, 32'd0);
    repeat (16) @(posedge clk);
    #1;
    checkOutput("b2b_done2", {31'd0, done}, 32'd1);
    checkOutput("b2b_q2", {16'd0, q}, 32'd30);
    checkOutput("b2b_r2", {16'd0, r}, 32'd10);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of an operation.
    $display("[TB] reset mid-operation");
    applyStimulus(16'd100, 16'd7);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_q", {16'd0, q}, 32'd0);
    checkOutput("arst_r", {16'd0, r}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_done", {31'd0, done}, 32'd0);
    checkOutput("arst_dz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    badBusy  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) doneSeen++;
      if (busy !== 1'b0) badBusy++;
    end
    checkOutput("arst_no_done", doneSeen, 32'd0);
    checkOutput("arst_no_busy", badBusy, 32'd0);
    runDivide(16'd100, 16'd7, 0);

    // Randomized operands: model comparison plus the division invariant.
    $display("[TB] randomized operations");
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = 16'd0;
        1, 2, 3: rb = 16'($urandom_range(1, 255));
        default: rb = 16'($urandom);
      endcase
      runDivide(ra, rb, 0);
      if (rb != 16'd0) begin
        recon = 32'(q) * 32'(rb) + 32'(r);
        checkOutput("inv_recon", recon, {16'd0, ra});
        checkOutput("inv_r_lt_b", {31'd0, (r < rb)}, 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
